// File: rtl/stream_gen_if.sv
// Valid/ready down-channel carrying the generated beats.
// The source drives valid and data; the sink returns ready.
interface stream_gen_if #(
    parameter int unsigned DW = 16
);
    logic          down_valid;
    logic [DW-1:0] down_data;
    logic          down_ready;

    modport master (output down_valid, output down_data, input down_ready);
    modport slave  (input down_valid, input down_data, output down_ready);
endinterface

// File: rtl/stream_gen.sv
// Valid/ready stimulus source: emits a programmed number of beats.
// Beats follow an incrementing or Galois LFSR sequence, with optional idle gaps.
module stream_gen #(
    parameter int unsigned   DW   = 16,
    parameter int unsigned   CW   = 16,
    parameter int unsigned   GAP  = 0,
    parameter logic [DW-1:0] POLY = DW'(16'hB400)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic          mode,
    input  logic [DW-1:0] seed,
    stream_gen_if.master  down,
    output logic          busy,
    output logic          done
);

    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d, data_adv;
    logic [CW-1:0] rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          mode_q, mode_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        data_adv = mode_q ? ((data_q >> 1) ^ (data_q[0] ? POLY : '0)) : data_q + DW'(1);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StSend;
                        rem_d   = count;
                        // An all-zero LFSR state would lock up, so it is nudged to 1.
                        data_d  = (mode && seed == '0) ? DW'(1) : seed;
                    end
                end
            end
            StSend: begin
                if (down.down_ready) begin
                    rem_d  = rem_q - CW'(1);
                    data_d = data_adv;
                    if (rem_q == CW'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (GAP != 0) begin
                        state_d = StWait;
                        gap_d   = GW'(GAP);
                    end
                end
            end
            StWait: begin
                if (gap_q <= GW'(1)) begin
                    state_d = StSend;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        valid_d = (state_d == StSend);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign down.down_valid = valid_q;
    assign down.down_data  = data_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
